// File: rtl/pulse_window_counter.sv
// ---------------------------------------------------------------------------
// pulse_window_counter
// Counts detector pulses inside fixed time windows delimited by edges of a
// slow timebase, and presents the count of the last completed window for
// readout with valid / overrun handshaking.
//
// Ports
//   clk_4mhz    in   1      system clock, all logic on posedge
//   reset_n     in   1      asynchronous active-low reset
//   pulse_in    in   1      asynchronous detector pulse, active-high
//   clk_5ms     in   1      asynchronous window timebase, each edge = boundary
//   rd_ack      in   1      synchronous single-cycle readout acknowledge
//   count_out   out  CNT_W  pulse count of the last completed window
//   sat_out     out  1      last completed window saturated
//   data_valid  out  1      count_out holds an unread result
//   overrun     out  1      sticky, a result was overwritten unread
// ---------------------------------------------------------------------------
module pulse_window_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_4mhz,
    input  logic             reset_n,
    input  logic             pulse_in,
    input  logic             clk_5ms,
    input  logic             rd_ack,
    output logic [CNT_W-1:0] count_out,
    output logic             sat_out,
    output logic             data_valid,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] ACC_ONE = CNT_W'(1);

    typedef enum logic {
        ALIGN = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_acc;
    logic             r_sat;

    logic r_pulse_s1;
    logic r_pulse_s2;
    logic r_pulse_d;
    logic r_win_s1;
    logic r_win_s2;
    logic r_win_d;

    logic w_pulse_edge;
    logic w_bnd;
    logic w_latch;

    // Two-flop synchronizers plus one history flop for edge detection.
    // Clearing to 0 means a low input at release produces no edge.
    always_ff @(posedge clk_4mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_s1 <= 1'b0;
            r_pulse_s2 <= 1'b0;
            r_pulse_d  <= 1'b0;
            r_win_s1   <= 1'b0;
            r_win_s2   <= 1'b0;
            r_win_d    <= 1'b0;
        end else begin
            r_pulse_s1 <= pulse_in;
            r_pulse_s2 <= r_pulse_s1;
            r_pulse_d  <= r_pulse_s2;
            r_win_s1   <= clk_5ms;
            r_win_s2   <= r_win_s1;
            r_win_d    <= r_win_s2;
        end
    end

    assign w_pulse_edge = r_pulse_s2 & ~r_pulse_d;
    assign w_bnd        = r_win_s2 ^ r_win_d;
    assign w_latch      = w_bnd && (r_state == COUNT);

    // Window FSM, accumulator and registered readout outputs.
    always_ff @(posedge clk_4mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ALIGN;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            count_out  <= '0;
            sat_out    <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (r_state)
                ALIGN: begin
                    // Partial window before the first boundary is discarded.
                    r_acc <= '0;
                    r_sat <= 1'b0;
                    if (w_bnd) begin
                        r_state <= COUNT;
                    end
                end
                COUNT: begin
                    if (w_bnd) begin
                        count_out  <= r_acc;
                        sat_out    <= r_sat;
                        data_valid <= 1'b1;
                        if (data_valid && !rd_ack) begin
                            overrun <= 1'b1;
                        end
                        // A pulse on the boundary cycle opens the new window.
                        r_acc <= w_pulse_edge ? ACC_ONE : '0;
                        r_sat <= w_pulse_edge && (ACC_ONE == ACC_MAX);
                    end else if (w_pulse_edge && (r_acc != ACC_MAX)) begin
                        r_acc <= r_acc + ACC_ONE;
                        if (r_acc == (ACC_MAX - ACC_ONE)) begin
                            r_sat <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ALIGN;
                end
            endcase

            // Readout acknowledge; a simultaneous latch keeps the new result valid.
            if (!w_latch && rd_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_window_counter.sv
module tb_pulse_window_counter;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic pulse_in = 1'b0;
    logic clk_5ms  = 1'b0;
    logic rd_ack   = 1'b0;

    logic [15:0] cnt16;
    logic        sat16, dv16, ov16;
    logic [3:0]  cnt4;
    logic        sat4, dv4, ov4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scheduled effective cycles of pulse edges and window boundaries.
    bit ps [0:65535];
    bit bs [0:65535];

    // Reference model: window-level pulse bookkeeping.
    bit m_align = 1'b1;
    int m_cnt   = 0;
    int m_last  = 0;
    bit m_dv    = 1'b0;
    bit m_ov    = 1'b0;

    always #5 clk = ~clk;

    pulse_window_counter #(.CNT_W(16)) u_dut16 (
        .clk_4mhz   (clk),
        .reset_n    (reset_n),
        .pulse_in   (pulse_in),
        .clk_5ms    (clk_5ms),
        .rd_ack     (rd_ack),
        .count_out  (cnt16),
        .sat_out    (sat16),
        .data_valid (dv16),
        .overrun    (ov16)
    );

    pulse_window_counter #(.CNT_W(4)) u_dut4 (
        .clk_4mhz   (clk),
        .reset_n    (reset_n),
        .pulse_in   (pulse_in),
        .clk_5ms    (clk_5ms),
        .rd_ack     (rd_ack),
        .count_out  (cnt4),
        .sat_out    (sat4),
        .data_valid (dv4),
        .overrun    (ov4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_align = 1'b1;
        m_cnt   = 0;
        m_last  = 0;
        m_dv    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic model_step(input bit p, input bit b, input bit a);
        bit latch;
        latch = 1'b0;
        if (m_align) begin
            if (b) m_align = 1'b0;
            m_cnt = 0;
        end else if (b) begin
            latch = 1'b1;
            if (m_dv && !a) m_ov = 1'b1;
            m_last = m_cnt;
            m_dv   = 1'b1;
            m_cnt  = p ? 1 : 0;
        end else begin
            m_cnt += p ? 1 : 0;
        end
        if (!latch && a && m_dv) begin
            m_dv = 1'b0;
            m_ov = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (reset_n) model_step(ps[cyc], bs[cyc], rd_ack);
        end
    end

    task automatic check_outputs();
        int e16;
        int e4;
        e16 = (m_last > 65535) ? 65535 : m_last;
        e4  = (m_last > 15) ? 15 : m_last;
        check("cnt16", 32'(cnt16), 32'(e16));
        check("sat16", 32'(sat16), 32'(m_last >= 65535));
        check("dv16",  32'(dv16),  32'(m_dv));
        check("ov16",  32'(ov16),  32'(m_ov));
        check("cnt4",  32'(cnt4),  32'(e4));
        check("sat4",  32'(sat4),  32'(m_last >= 15));
        check("dv4",   32'(dv4),   32'(m_dv));
        check("ov4",   32'(ov4),   32'(m_ov));
    endtask

    // One cycle: check state, then drive inputs for the next posedge.
    task automatic tick(input bit p, input bit c, input bit a);
        int n;
        @(negedge clk);
        check_outputs();
        n = cyc + 3;
        if (reset_n) begin
            if (p && !pulse_in) ps[n] = 1'b1;
            if (c !== clk_5ms)  bs[n] = 1'b1;
        end
        pulse_in = p;
        clk_5ms  = c;
        rd_ack   = a;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(pulse_in, clk_5ms, 1'b0);
    endtask

    task automatic toggle();
        tick(pulse_in, ~clk_5ms, 1'b0);
    endtask

    task automatic ack();
        tick(pulse_in, clk_5ms, 1'b1);
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        repeat (n) begin
            repeat (hi) tick(1'b1, clk_5ms, 1'b0);
            repeat (lo) tick(1'b0, clk_5ms, 1'b0);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        if (clk_5ms) bs[cyc + 3] = 1'b1;
    endtask

    task automatic apply_reset(input int n, input bit c5);
        @(negedge clk);
        check_outputs();
        reset_n  = 1'b0;
        pulse_in = 1'b0;
        rd_ack   = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            ps[cyc + i] = 1'b0;
            bs[cyc + i] = 1'b0;
        end
        #1;
        check("rst_cnt16", 32'(cnt16), 32'd0);
        check("rst_dv16",  32'(dv16),  32'd0);
        check("rst_ov16",  32'(ov16),  32'd0);
        check("rst_sat4",  32'(sat4),  32'd0);
        repeat (n - 1) tick(1'b0, c5, 1'b0);
        release_reset();
    endtask

    initial begin
        int p_left;
        int w_left;
        bit a;
        model_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("reset_cnt16", 32'(cnt16), 32'd0);
        check("reset_dv16",  32'(dv16),  32'd0);
        release_reset();

        // Pulses before the first boundary are ignored.
        idle(5);
        pulses(3, 3, 3);
        toggle();
        idle(4);
        check("align_no_latch", 32'(dv16), 32'd0);

        // 100 pulses, period 40.
        pulses(100, 20, 20);
        toggle();
        idle(4);
        check("w100_cnt16", 32'(cnt16), 32'd100);
        check("w100_dv",    32'(dv16),  32'd1);
        check("w100_sat16", 32'(sat16), 32'd0);
        check("w100_ov",    32'(ov16),  32'd0);
        check("w100_cnt4",  32'(cnt4),  32'd15);
        ack();
        idle(2);
        check("ack_dv", 32'(dv16), 32'd0);

        // Pulse edge coincident with boundary belongs to the new window.
        pulses(5, 3, 3);
        tick(1'b1, ~clk_5ms, 1'b0);
        tick(1'b1, clk_5ms, 1'b0);
        idle(2);
        tick(1'b0, clk_5ms, 1'b0);
        check("coinc_close", 32'(cnt16), 32'd5);
        idle(2);
        pulses(3, 3, 3);
        toggle();
        idle(4);
        check("coinc_next", 32'(cnt16), 32'd4);
        check("coinc_ov",   32'(ov16),  32'd1);

        // Overrun clear, then two unread windows.
        ack();
        idle(2);
        check("ov_clr_dv", 32'(dv16), 32'd0);
        check("ov_clr_ov", 32'(ov16), 32'd0);
        pulses(2, 3, 3);
        toggle();
        pulses(6, 3, 3);
        toggle();
        idle(4);
        check("ov_set",  32'(ov16),  32'd1);
        check("ov_cnt",  32'(cnt16), 32'd6);
        ack();
        idle(2);
        check("ov_ack_dv", 32'(dv16), 32'd0);
        check("ov_ack_ov", 32'(ov16), 32'd0);

        // rd_ack on the boundary cycle.
        pulses(4, 3, 3);
        toggle();
        idle(4);
        pulses(9, 3, 3);
        toggle();
        idle(1);
        ack();
        idle(3);
        check("ackbnd_dv",  32'(dv16),  32'd1);
        check("ackbnd_ov",  32'(ov16),  32'd0);
        check("ackbnd_cnt", 32'(cnt16), 32'd9);

        // Saturation in the 4-bit instance.
        pulses(20, 3, 3);
        toggle();
        idle(4);
        check("sat_cnt4", 32'(cnt4), 32'd15);
        check("sat_sat4", 32'(sat4), 32'd1);
        check("sat_cnt16", 32'(cnt16), 32'd20);
        pulses(3, 3, 3);
        toggle();
        idle(4);
        check("unsat_cnt4", 32'(cnt4), 32'd3);
        check("unsat_sat4", 32'(sat4), 32'd0);

        // Mid-window reset discards partial count.
        ack();
        pulses(50, 3, 3);
        apply_reset(5, 1'b0);
        idle(3);
        pulses(10, 3, 3);
        toggle();
        idle(4);
        check("rst_first_bnd", 32'(dv16), 32'd0);
        pulses(7, 3, 3);
        toggle();
        idle(4);
        check("rst_second_cnt", 32'(cnt16), 32'd7);
        check("rst_second_dv",  32'(dv16),  32'd1);

        // Release with timebase high: that edge is the alignment boundary.
        apply_reset(5, 1'b1);
        idle(6);
        pulses(4, 3, 3);
        toggle();
        idle(4);
        check("hi_rel_cnt", 32'(cnt16), 32'd4);
        check("hi_rel_dv",  32'(dv16),  32'd1);

        // Randomized traffic.
        p_left = 3;
        w_left = 20;
        for (int i = 0; i < 4000; i++) begin
            bit p;
            bit c;
            if (i == 2000) begin
                apply_reset($urandom_range(1, 6), 1'($urandom_range(0, 1)));
                p_left = 3;
            end
            p = pulse_in;
            c = clk_5ms;
            p_left--;
            if (p_left == 0) begin
                p = ~p;
                p_left = $urandom_range(2, 12);
            end
            w_left--;
            if (w_left == 0) begin
                c = ~c;
                w_left = $urandom_range(4, 200);
            end
            a = ($urandom_range(0, 15) == 0);
            tick(p, c, a);
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_window_counter.md
PULSE_WINDOW_COUNTER -- requirements
Module: pulse_window_counter

Interface
REQ-001 Parameter CNT_W, default 16: width of the pulse accumulator and count_out.
REQ-002 clk_4mhz  input  1  system clock, 4 MHz, from clock_4mhz; all logic on posedge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 pulse_in  input  1  detector pulse, asynchronous to clk_4mhz, active-high, min high/low width 2 clk_4mhz periods.
REQ-005 clk_5ms  input  1  window timebase from clock_5ms; toggles every 5 ms, so each edge marks one window boundary.
REQ-006 rd_ack  input  1  readout acknowledge, synchronous, single-cycle pulse.
REQ-007 count_out  output  CNT_W  pulse count of the last completed window.
REQ-008 sat_out  output  1  last completed window saturated.
REQ-009 data_valid  output  1  count_out holds an unread window result.
REQ-010 overrun  output  1  sticky; a window result was overwritten unread.

Function
REQ-011 pulse_in SHALL pass a 2-flop synchronizer plus 1 edge-detect flop; a rising edge SHALL count once, on the 3rd posedge after the input transition.
REQ-012 clk_5ms SHALL pass an identical synchronizer; either edge of the synchronized signal SHALL be one boundary event (bnd), 1 cycle wide.
REQ-013 FSM states: ALIGN, COUNT. Reset enters ALIGN.
REQ-014 ALIGN: accumulator held at 0, pulses ignored, no result latched; the first bnd SHALL move to COUNT with acc = 0.
REQ-015 COUNT: each counted pulse edge SHALL increment acc by 1.
REQ-016 acc SHALL saturate at 2^CNT_W-1 and set internal sat flag; further pulses are not counted; no wrap to 0.
REQ-017 On bnd in COUNT: count_out <= acc, sat_out <= sat, data_valid <= 1, acc restarts. Outputs update on the posedge after bnd is detected (1-cycle latency).
REQ-018 A pulse edge coinciding with bnd SHALL be counted in the new window (acc <= 1), not the closing one.
REQ-019 rd_ack with data_valid = 1 SHALL clear data_valid and overrun on the next posedge; rd_ack with data_valid = 0 has no effect.
REQ-020 bnd while data_valid = 1 and rd_ack = 0 SHALL set overrun; new result still overwrites count_out.
REQ-021 bnd and rd_ack in the same cycle: new result latched, data_valid stays 1, overrun unchanged (not set, not cleared).
REQ-022 count_out and sat_out SHALL be stable while data_valid = 1 except on bnd.

Reset
REQ-023 reset_n = 0 SHALL asynchronously force count_out = 0, sat_out = 0, data_valid = 0, overrun = 0, acc = 0, sat = 0, synchronizers = 0, state = ALIGN.
REQ-024 Reset mid-window SHALL discard the partial count; after release, counting resumes only after the next bnd.
REQ-025 Synchronizer clearing SHALL NOT create a spurious bnd or pulse edge on release when the inputs are low. If clk_5ms is high at release, one bnd SHALL occur; it counts as the ALIGN exit.

Verification
REQ-026 Reset release, then 1st bnd, then 100 pulses (period 40 clk), then 2nd bnd -> count_out = 100, data_valid = 1, sat_out = 0, overrun = 0.
REQ-027 Pulse edge forced in the same cycle as bnd -> closing window excludes it; next window result = 1 + subsequent pulses.
REQ-028 CNT_W = 4, 20 pulses in one window -> count_out = 15, sat_out = 1; next window with 3 pulses -> count_out = 3, sat_out = 0.
REQ-029 Two windows with no rd_ack -> overrun = 1, count_out = 2nd result; rd_ack -> data_valid = 0, overrun = 0.
REQ-030 rd_ack in the same cycle as bnd -> data_valid = 1 with the new count, overrun = 0.
REQ-031 reset_n low for 5 clk mid-window with 50 pulses accumulated -> all outputs 0 immediately; the first post-reset bnd latches nothing; the second latches only pulses after the first.
